shifter_rr_arbiter: RTL and testbench
=====================================

// Module: shifter_rr_arbiter
// PURPOSE
//  Shares one barrelshifter32 instance among NREQ requesters.
//  Round-robin arbitration, valid/ready request handshake per requester, and a registered
//  result slot with the winner's ID.
//  Sits between ALU-side clients (e.g. address-gen, multi-issue ALU slots) and the shifter datapath.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  IDW    2   requester-ID width, = clog2(NREQ), min 1
// PORTS
//  clk         in   1          rising-edge clock, single clock domain
//  rst_n       in   1          asynchronous active-low reset
//  req_valid   in   NREQ       requester i has an operation pending
//  req_ready   out  NREQ       one-hot grant; transfer on req_valid[i]&req_ready[i]
//  req_a       in   32*NREQ    operand a, requester i at [32*i+:32]
//  req_b       in   5*NREQ     shift amount, requester i at [5*i+:5]
//  req_aluc    in   2*NREQ     op code, requester i at [2*i+:2]
//  resp_valid  out  1          result slot full
//  resp_ready  in   1          consumer takes result when resp_valid&resp_ready
//  resp_c      out  32         shifter result
//  resp_id     out  IDW        index of requester that issued the result
//  busy_cnt    out  16         cycles with resp_valid&!resp_ready, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): resp_valid=0, resp_c=0, resp_id=0, busy_cnt=0.
//   Reset also sets the RR pointer to 0 and req_ready to 0.
//  Op codes pass to shifter unchanged:
//   00 = signed divide by 2**b (rounds toward zero, NOT sra).
//   01 = shl. 10 = srl. 11 = shl.
//  slot_free = !resp_valid | resp_ready (same-cycle drain+refill allowed, full throughput).
//  req_ready is combinational. At most one bit is set, and only when slot_free.
//   The grant goes to the first valid i scanning from ptr upward, with wrap-around.
//  Grant never depends on resp_ready while resp_valid=0.
//  On a transfer from requester g:
//   - resp_c <= shifter(req_a[g],req_b[g],req_aluc[g]); resp_id <= g; resp_valid <= 1.
//   - ptr <= (g==NREQ-1) ? 0 : g+1.
//  Latency: exactly 1 cycle, request transfer to resp_valid.
//  No transfer: ptr holds. If resp_ready and resp_valid, resp_valid <= 0.
//  Stall (resp_valid & !resp_ready): resp_c and resp_id are held stable and req_ready=0.
//   busy_cnt increments each stall cycle and saturates at 16'hFFFF.
//  Requesters must hold payload stable while valid&!ready; the block does not re-sample it.
//  Reset mid-operation: a pending result is dropped and no response is emitted for it.
//  b=0: resp_c = a for all ops. Operand width is fixed at 32; there is no sign-extension logic here.
//  Only the shifter instance is combinational. Every output other than req_ready is a flop.
// STRUCTURE
//  Package shifter_pkg: localparams OP_DIV2N=2'b00, OP_SHL=2'b01, OP_SRL=2'b10, OP_SHL2=2'b11.
//   It also holds DW=32 and SHW=5.
//  Sub-module rr_pick (NREQ): inputs req vector and ptr; outputs one-hot gnt and encoded idx.
//   rr_pick is pure combinational.
//  Top: operand mux by idx, one barrelshifter32 instance, result/ID/valid regs, ptr reg, busy_cnt.
// TESTING
//  1 Single req: req0 a=32'h0000_00F0, b=4, aluc=10, resp_ready=1.
//    -> one cycle later resp_c=32'h0000_000F, id=0, resp_valid=1 for 1 cycle.
//  2 All 4 valid every cycle, resp_ready=1, each op shl a=1 b=i.
//    -> grants 0,1,2,3,0,... one per cycle; resp_c sequence 1,2,4,8,1.
//  3 Backpressure: resp_ready=0 for 5 cycles with result held.
//    -> resp_c/resp_id stable, req_ready=0, busy_cnt=5.
//    -> resp_ready=1 then drains and refills in the same cycle.
//  4 aluc=00 with a=32'hFFFF_FFF9 (-7), b=1.
//    -> resp_c=32'hFFFF_FFFD (-3), not FFFF_FFFC.
//    -> b=0 on every op returns a.
//  5 ptr=2, only req1 and req3 valid -> grant req3 first, then req1 (wrap).
//  6 rst_n low while resp_valid=1 and reqs valid.
//    -> outputs immediately 0, busy_cnt=0.
//    -> after release the first grant goes to req0.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared widths and op codes for the shared shifter arbiter
package shifter_pkg;
    localparam int DW  = 32;
    localparam int SHW = 5;

    localparam logic [1:0] OP_DIV2N = 2'b00;
    localparam logic [1:0] OP_SHL   = 2'b01;
    localparam logic [1:0] OP_SRL   = 2'b10;
    localparam logic [1:0] OP_SHL2  = 2'b11;
endpackage

// File: rtl/barrelshifter32.sv
// rtl/barrelshifter32.sv - combinational 32-bit shifter with signed power-of-two divide
module barrelshifter32
    import shifter_pkg::*;
(
    input  logic [DW-1:0]  a,
    input  logic [SHW-1:0] b,
    input  logic [1:0]     aluc,
    output logic [DW-1:0]  c
);
    logic [DW-1:0] mask;
    logic [DW-1:0] biased;

    // Negative dividends get a bias of 2**b-1 so the arithmetic shift truncates toward zero.
    assign mask   = ~({DW{1'b1}} << b);
    assign biased = a[DW-1] ? a + mask : a;

    always_comb begin
        c = a;
        case (aluc)
            OP_DIV2N: c = DW'($signed(biased) >>> b);
            OP_SRL:   c = a >> b;
            OP_SHL,
            OP_SHL2:  c = a << b;
            default:  c = a;
        endcase
    end
endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first valid request at or above ptr, with wrap
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/shifter_rr_arbiter.sv
// rtl/shifter_rr_arbiter.sv - round-robin sharing of one barrelshifter32 with a registered result slot
module shifter_rr_arbiter
    import shifter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [DW*NREQ-1:0]  req_a,
    input  logic [SHW*NREQ-1:0] req_b,
    input  logic [2*NREQ-1:0]   req_aluc,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DW-1:0]       resp_c,
    output logic [IDW-1:0]      resp_id,
    output logic [15:0]         busy_cnt
);
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            slot_free;
    logic            xfer;
    logic [DW-1:0]   sh_a;
    logic [SHW-1:0]  sh_b;
    logic [1:0]      sh_aluc;
    logic [DW-1:0]   sh_c;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Draining and refilling the slot in the same cycle keeps one result per cycle.
    assign slot_free = !resp_valid || resp_ready;
    assign req_ready = (slot_free && rst_n) ? pick_gnt : '0;
    assign xfer      = |(req_valid & req_ready);

    assign sh_a    = req_a[DW*pick_idx +: DW];
    assign sh_b    = req_b[SHW*pick_idx +: SHW];
    assign sh_aluc = req_aluc[2*pick_idx +: 2];

    barrelshifter32 u_shift (
        .a    (sh_a),
        .b    (sh_b),
        .aluc (sh_aluc),
        .c    (sh_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_c     <= '0;
            resp_id    <= '0;
            ptr        <= '0;
            busy_cnt   <= '0;
        end else begin
            if (xfer) begin
                resp_c     <= sh_c;
                resp_id    <= pick_idx;
                resp_valid <= 1'b1;
                ptr        <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (resp_valid && !resp_ready && busy_cnt != 16'hFFFF)
                busy_cnt <= busy_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// tb/tb_shifter_rr_arbiter.sv - randomized and directed checks against a behavioural model
module tb_shifter_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [5*NREQ-1:0]   req_b;
    logic [2*NREQ-1:0]   req_aluc;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_c;
    logic [IDW-1:0]      resp_id;
    logic [15:0]         busy_cnt;

    int n_chk = 0;
    int n_err = 0;

    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_c;
    int          m_id;
    int          m_busy;
    logic [NREQ-1:0] last_gnt;
    logic [31:0] held_c;

    always #5 clk = ~clk;

    shifter_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_aluc   (req_aluc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_c     (resp_c),
        .resp_id    (resp_id),
        .busy_cnt   (busy_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int b, input int op);
        longint sa;
        case (op)
            0: begin
                sa = longint'($signed(a));
                return 32'(sa / (longint'(1) << b));
            end
            2:       return a >> b;
            default: return a << b;
        endcase
    endfunction

    task automatic set_req(input int i, input bit v, input logic [31:0] a,
                           input logic [4:0] b, input logic [1:0] op);
        req_valid[i]       = v;
        req_a[32*i +: 32]  = a;
        req_b[5*i +: 5]    = b;
        req_aluc[2*i +: 2] = op;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_c = 0; m_id = 0; m_busy = 0;
    endtask

    // Inputs are already driven; check the grant, advance the model, then check the slot.
    task automatic step();
        int g;
        int j;
        logic [NREQ-1:0] eg;
        #1;
        g = -1;
        if (!m_valid || resp_ready)
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[j]) g = j;
            end
        eg = (g >= 0) ? NREQ'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(eg));
        if (m_valid && !resp_ready && m_busy < 65535) m_busy++;
        if (g >= 0) begin
            m_c     = ref_shift(req_a[32*g +: 32], int'(req_b[5*g +: 5]), int'(req_aluc[2*g +: 2]));
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % NREQ;
        end else if (resp_ready) begin
            m_valid = 0;
        end
        last_gnt = eg;
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("resp_c", resp_c, m_c);
            chk("resp_id", 32'(resp_id), 32'(m_id));
        end
        chk("busy_cnt", 32'(busy_cnt), 32'(m_busy));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst resp_valid", 32'(resp_valid), 0);
        chk("rst resp_c", resp_c, 0);
        chk("rst resp_id", 32'(resp_id), 0);
        chk("rst busy_cnt", 32'(busy_cnt), 0);
        chk("rst req_ready", 32'(req_ready), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [NREQ-1:0] hold;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_aluc = '0; resp_ready = 1'b1;
        last_gnt = '0;
        @(negedge clk);
        do_reset();

        // single request, srl
        set_req(0, 1, 32'h0000_00F0, 5'd4, 2'b10);
        step();
        chk("t1 resp_c", resp_c, 32'h0000_000F);
        chk("t1 resp_id", 32'(resp_id), 0);
        req_valid = '0;
        step();
        chk("t1 one-shot", 32'(resp_valid), 0);

        // all requesters, round-robin order from ptr 0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 32'd1, 5'(i), 2'b01);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t2 id seq", 32'(resp_id), 32'(n % NREQ));
            chk("t2 c seq", resp_c, 32'd1 << (n % NREQ));
        end

        // backpressure, then drain and refill in one cycle
        held_c = resp_c;
        resp_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t3 held c", resp_c, held_c);
        end
        chk("t3 busy5", 32'(busy_cnt), 5);
        resp_ready = 1'b1;
        step();
        chk("t3 refill valid", 32'(resp_valid), 1);

        // signed divide rounds toward zero; b=0 is identity
        req_valid = '0;
        set_req(0, 1, 32'hFFFF_FFF9, 5'd1, 2'b00);
        step();
        chk("t4 div", resp_c, 32'hFFFF_FFFD);
        for (int op = 0; op < 4; op++) begin
            ra = $urandom();
            set_req(0, 1, ra, 5'd0, 2'(op));
            step();
            chk("t4 b0", resp_c, ra);
        end

        // wrap-around from ptr 2
        do_reset();
        req_valid = '0;
        set_req(1, 1, 32'h8000_0000, 5'd31, 2'b10);
        step();
        set_req(3, 1, 32'h1234_5678, 5'd8, 2'b01);
        step();
        chk("t5 first", 32'(last_gnt), 32'b1000);
        req_valid[3] = 1'b0;
        step();
        chk("t5 wrap", 32'(last_gnt), 32'b0010);

        // reset mid-operation with a stalled result
        req_valid = '1;
        resp_ready = 1'b0;
        step();
        step();
        do_reset();
        resp_ready = 1'b1;
        step();
        chk("t6 first grant", 32'(last_gnt), 32'b0001);

        // randomized traffic; stalled requesters hold their payload
        for (int n = 0; n < 3000; n++) begin
            hold = req_valid & ~last_gnt;
            for (int i = 0; i < NREQ; i++)
                if (!hold[i])
                    set_req(i, 1'($urandom_range(0, 1)), $urandom(),
                            5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
